instr_mem_pipe: RTL and testbench

- Parametrised, clocked successor to the combinational instruction ROM used by the pipelined RV64 core.
- Byte-addressed, little-endian storage with a registered fetch path of configurable latency (1 or 2) and stall/flush control driven by the IF-stage hazard unit.
- A byte-wide program-load port lets the testbench or a boot loader write the image at run time.
- Misaligned and out-of-range fetches are flagged and return a NOP instead of X.

---
 rtl/instr_mem_pipe_pkg.sv | 16 +
 rtl/instr_mem_array.sv | 49 ++++
 rtl/instr_mem_pipe.sv | 113 +++++++++++
 tb/tb_instr_mem_pipe.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pipe_pkg.sv
// Shared constants and payload types for the pipelined instruction memory.
package instr_mem_pipe_pkg;

    localparam int unsigned INST_W     = 32;
    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 2;

    localparam logic [INST_W-1:0] NOP_INST_DEF = 32'h0000_0013;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic              misaligned;
        logic              out_of_range;
    } word_rsp_t;

endpackage

// File: rtl/instr_mem_array.sv
// Byte-wide program RAM with a combinational little-endian word read and
// fetch fault detection (misalignment first, then range).
module instr_mem_array
    import instr_mem_pipe_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 64,
    parameter int unsigned       DEPTH    = 256,
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic              clk,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [7:0]        prog_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output word_rsp_t         rd_rsp_c
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [7:0]        mem_q [DEPTH];
    logic              prog_hit_c;
    logic [ADDR_W:0]   rd_end_c;
    logic [IDX_W-1:0]  rd_base_c;

    assign prog_hit_c = prog_addr < ADDR_W'(DEPTH);
    // one extra bit so the last-byte address can never wrap back into range
    assign rd_end_c   = {1'b0, rd_addr} + (ADDR_W+1)'(3);
    assign rd_base_c  = {rd_addr[IDX_W-1:2], 2'b00};

    // Storage has no reset so a loaded image survives a core reset.
    always_ff @(posedge clk) begin
        if (prog_we && prog_hit_c) begin
            mem_q[prog_addr[IDX_W-1:0]] <= prog_data;
        end
    end

    always_comb begin
        rd_rsp_c = '{inst: NOP_INST, misaligned: 1'b0, out_of_range: 1'b0};
        if (rd_addr[1:0] != 2'b00) begin
            rd_rsp_c.misaligned = 1'b1;
        end else if (rd_end_c >= (ADDR_W+1)'(DEPTH)) begin
            rd_rsp_c.out_of_range = 1'b1;
        end else begin
            rd_rsp_c.inst = {mem_q[rd_base_c + IDX_W'(3)], mem_q[rd_base_c + IDX_W'(2)],
                             mem_q[rd_base_c + IDX_W'(1)], mem_q[rd_base_c]};
        end
    end

endmodule

// File: rtl/instr_mem_pipe.sv
// Clocked instruction memory for the RV64 IF stage: 1- or 2-cycle fetch
// pipeline with stall/flush control and a byte-wide program-load port.
module instr_mem_pipe
    import instr_mem_pipe_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 64,
    parameter int unsigned       DEPTH        = 256,
    parameter int unsigned       READ_LATENCY = 1,
    parameter logic [INST_W-1:0] NOP_INST     = NOP_INST_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    input  logic              stall,
    input  logic              flush,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              misaligned,
    output logic              out_of_range,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [7:0]        prog_data
);

    localparam int unsigned LAT = (READ_LATENCY < RD_LAT_MIN) ? RD_LAT_MIN :
                                  (READ_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX : READ_LATENCY;
    localparam bit TWO_STAGE = (LAT == RD_LAT_MAX);

    logic              accept_c;
    word_rsp_t         rd_rsp_c;
    logic              src_live_c;
    word_rsp_t         src_rsp_c;
    logic [ADDR_W-1:0] src_pc_c;

    logic              s1_valid_q, s1_valid_d;
    word_rsp_t         s1_rsp_q, s1_rsp_d;
    logic [ADDR_W-1:0] s1_pc_q, s1_pc_d;
    logic              inst_valid_q, inst_valid_d;
    word_rsp_t         out_rsp_q, out_rsp_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;

    assign fetch_ready = !stall && !prog_we;
    assign accept_c    = fetch_req && fetch_ready;

    instr_mem_array #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .NOP_INST (NOP_INST)
    ) u_array (
        .clk       (clk),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .rd_addr   (fetch_addr),
        .rd_rsp_c  (rd_rsp_c)
    );

    // Output stage is fed by the extra stage, or straight from the array at latency 1.
    assign src_live_c = TWO_STAGE ? (s1_valid_q && !flush) : accept_c;
    assign src_rsp_c  = TWO_STAGE ? s1_rsp_q : rd_rsp_c;
    assign src_pc_c   = TWO_STAGE ? s1_pc_q  : fetch_addr;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_rsp_d     = s1_rsp_q;
        s1_pc_d      = s1_pc_q;
        inst_valid_d = inst_valid_q;
        out_rsp_d    = out_rsp_q;
        out_pc_d     = out_pc_q;

        // flush beats stall for valid bits; payloads only move when not stalled
        if (!stall || flush) begin
            s1_valid_d   = TWO_STAGE && accept_c;
            inst_valid_d = src_live_c;
        end
        if (!stall && accept_c && TWO_STAGE) begin
            s1_rsp_d = rd_rsp_c;
            s1_pc_d  = fetch_addr;
        end
        if (!stall && src_live_c) begin
            out_rsp_d = src_rsp_c;
            out_pc_d  = src_pc_c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q   <= 1'b0;
            s1_rsp_q     <= '0;
            s1_pc_q      <= '0;
            inst_valid_q <= 1'b0;
            out_rsp_q    <= '0;
            out_pc_q     <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_rsp_q     <= s1_rsp_d;
            s1_pc_q      <= s1_pc_d;
            inst_valid_q <= inst_valid_d;
            out_rsp_q    <= out_rsp_d;
            out_pc_q     <= out_pc_d;
        end
    end

    assign inst_valid   = inst_valid_q;
    assign inst_out     = out_rsp_q.inst;
    assign inst_pc      = out_pc_q;
    assign misaligned   = out_rsp_q.misaligned;
    assign out_of_range = out_rsp_q.out_of_range;

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Scoreboard bench for instr_mem_pipe: latency-1 and latency-2 instances share
// one stimulus stream and are checked against an in-flight-list reference model.
module tb_instr_mem_pipe;
    import instr_mem_pipe_pkg::*;

    localparam int unsigned AW     = 64;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned N_RAND = 3000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]   word;
        logic [AW-1:0] pc;
        logic          mis;
        logic          oor;
    } item_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          fetch_req = 1'b0, stall = 1'b0, flush = 1'b0, prog_we = 1'b0;
    logic [AW-1:0] fetch_addr = '0, prog_addr = '0;
    logic [7:0]    prog_data = '0;
    logic [1:0]    fr_w, iv_w, mis_w, oor_w;
    logic [31:0]   io_w [2];
    logic [AW-1:0] pc_w [2];

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mm [DEPTH];
    item_t      sb0[$], sb1[$];
    item_t      pend_it [2][2];
    bit         pend_v [2][2];
    int         pend_rem [2][2];
    bit         exp_valid [2], exp_valid_nx [2], prev_valid [2];
    item_t      held [2];
    item_t      mon_got, mon_want;
    bit         edge_stalled = 1'b0;
    bit         mon_en = 1'b0;

    always #5 clk = ~clk;

    instr_mem_pipe #(.ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(1), .NOP_INST(NOP)) u_dut_l1 (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(fr_w[0]), .stall(stall), .flush(flush), .inst_valid(iv_w[0]),
        .inst_out(io_w[0]), .inst_pc(pc_w[0]), .misaligned(mis_w[0]), .out_of_range(oor_w[0]),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data));

    instr_mem_pipe #(.ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(2), .NOP_INST(NOP)) u_dut_l2 (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(fr_w[1]), .stall(stall), .flush(flush), .inst_valid(iv_w[1]),
        .inst_out(io_w[1]), .inst_pc(pc_w[1]), .misaligned(mis_w[1]), .out_of_range(oor_w[1]),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_push(input int d, input item_t it);
        if (d == 0) sb0.push_back(it);
        else        sb1.push_back(it);
    endtask

    // Expected fetch result straight from the memory image and the fault rules.
    function automatic item_t expect_fetch(input logic [AW-1:0] a);
        item_t      it;
        logic [7:0] ia;
        it.pc   = a;
        it.mis  = (a[1:0] != 2'b00);
        it.oor  = !it.mis && (a >= AW'(DEPTH - 3));
        it.word = NOP;
        if (!it.mis && !it.oor) begin
            ia      = 8'(a);
            it.word = {mm[ia + 8'd3], mm[ia + 8'd2], mm[ia + 8'd1], mm[ia]};
        end
        return it;
    endfunction

    // Each in-flight fetch counts down its remaining cycles; stall freezes, flush kills.
    task automatic model_edge(input int d, input bit acc, input item_t it, input bit fl, input bit st);
        int lat;
        bit shown;
        bit placed;
        lat    = d + 1;
        shown  = 1'b0;
        placed = 1'b0;
        if (st && !fl) begin
            exp_valid_nx[d] = exp_valid[d];
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (pend_v[d][k]) begin
                if (fl) begin
                    pend_v[d][k] = 1'b0;
                end else begin
                    pend_rem[d][k]--;
                    if (pend_rem[d][k] == 0) begin
                        sb_push(d, pend_it[d][k]);
                        pend_v[d][k] = 1'b0;
                        shown = 1'b1;
                    end
                end
            end
        end
        if (acc) begin
            if (lat == 1) begin
                sb_push(d, it);
                shown = 1'b1;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (!pend_v[d][k] && !placed) begin
                        pend_v[d][k]   = 1'b1;
                        pend_rem[d][k] = lat - 1;
                        pend_it[d][k]  = it;
                        placed = 1'b1;
                    end
                end
            end
        end
        exp_valid_nx[d] = shown;
    endtask

    task automatic step(input bit req, input logic [AW-1:0] addr, input bit st, input bit fl,
                        input bit we, input logic [AW-1:0] pa, input logic [7:0] pd);
        item_t it;
        bit    acc;
        fetch_req = req; fetch_addr = addr; stall = st; flush = fl;
        prog_we = we; prog_addr = pa; prog_data = pd;
        #1;
        acc = req && !st && !we;
        for (int d = 0; d < 2; d++)
            check($sformatf("fetch_ready_l%0d", d + 1), 128'(fr_w[d]), 128'(!st && !we));
        it = expect_fetch(addr);
        for (int d = 0; d < 2; d++) model_edge(d, acc, it, fl, st);
        if (we && pa < AW'(DEPTH)) mm[8'(pa)] = pd;
        @(posedge clk);
        exp_valid = exp_valid_nx;
        @(negedge clk);
        #1;
    endtask

    task automatic fetch(input logic [AW-1:0] a);
        step(1'b1, a, 1'b0, 1'b0, 1'b0, '0, 8'h00);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 8'h00);
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [7:0] b);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, a, b);
    endtask

    task automatic expect_out(input int d, input string name, input bit v, input logic [31:0] w);
        check({name, "_valid"}, 128'(iv_w[d]), 128'(v));
        if (v) check({name, "_word"}, 128'(io_w[d]), 128'(w));
    endtask

    task automatic expect_flags(input int d, input string name, input bit m, input bit o);
        check({name, "_mis"}, 128'(mis_w[d]), 128'(m));
        check({name, "_oor"}, 128'(oor_w[d]), 128'(o));
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 2; k++) pend_v[d][k] = 1'b0;
            exp_valid[d]    = 1'b0;
            exp_valid_nx[d] = 1'b0;
            prev_valid[d]   = 1'b0;
        end
        sb0.delete();
        sb1.delete();
    endtask

    always @(posedge clk) edge_stalled <= stall && !flush;

    // Monitor: pops a new expectation whenever a DUT presents a fresh result.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("inst_valid_l%0d", d + 1), 128'(iv_w[d]), 128'(exp_valid[d]));
                if (iv_w[d]) begin
                    mon_got = {io_w[d], pc_w[d], mis_w[d], oor_w[d]};
                    if (edge_stalled && prev_valid[d]) begin
                        mon_want = held[d];
                    end else if ((d == 0) ? (sb0.size() == 0) : (sb1.size() == 0)) begin
                        miscompares++;
                        $display("FAIL unexpected_output_l%0d: got %0h required nothing", d + 1, mon_got);
                        mon_want = mon_got;
                    end else begin
                        mon_want = (d == 0) ? sb0.pop_front() : sb1.pop_front();
                    end
                    held[d] = mon_want;
                    check($sformatf("rsp_l%0d", d + 1), 128'(mon_got), 128'(mon_want));
                end
                prev_valid[d] = iv_w[d];
            end
        end
    end

    initial begin
        clear_model();
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_valid_l%0d", d + 1), 128'(iv_w[d]), 128'(0));
            check($sformatf("rst_out_l%0d", d + 1), 128'(io_w[d]), 128'(0));
            check($sformatf("rst_pc_l%0d", d + 1), 128'(pc_w[d]), 128'(0));
            check($sformatf("rst_mis_l%0d", d + 1), 128'(mis_w[d]), 128'(0));
            check($sformatf("rst_oor_l%0d", d + 1), 128'(oor_w[d]), 128'(0));
        end
        reset  = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < int'(DEPTH); i++) write(AW'(i), 8'($urandom));

        write(0, 8'h93); write(1, 8'h05); write(2, 8'h60); write(3, 8'h00);
        write(4, 8'h93); write(5, 8'h0E); write(6, 8'h60); write(7, 8'h00);
        write(8, 8'h13); write(9, 8'h0F); write(10, 8'h00); write(11, 8'h00);
        write(AW'(DEPTH), 8'hAA);
        write(64'hFFFF_FFFF_FFFF_FF00, 8'h55);

        fetch(0);  expect_out(0, "first_l1", 1'b1, 32'h0060_0593);
        check("first_pc_l1", 128'(pc_w[0]), 128'(0));
        expect_flags(0, "first_l1", 1'b0, 1'b0);
        idle();    expect_out(1, "first_l2", 1'b1, 32'h0060_0593);

        fetch(0);  expect_out(0, "b2b0_l1", 1'b1, 32'h0060_0593);
        fetch(4);  expect_out(0, "b2b1_l1", 1'b1, 32'h0060_0E93);
        fetch(8);  expect_out(0, "b2b2_l1", 1'b1, 32'h0000_0F13);
        idle();    expect_out(1, "b2b2_l2", 1'b1, 32'h0000_0F13);
        idle();

        fetch(2);   expect_out(0, "mis2", 1'b1, NOP);  expect_flags(0, "mis2", 1'b1, 1'b0);
        fetch(254); expect_out(0, "mis254", 1'b1, NOP); expect_flags(0, "mis254", 1'b1, 1'b0);
        fetch(252); expect_flags(0, "ok252", 1'b0, 1'b0);
        fetch(256); expect_out(0, "oor256", 1'b1, NOP); expect_flags(0, "oor256", 1'b0, 1'b1);
        fetch(64'hFFFF_FFFF_FFFF_FFFC); expect_flags(0, "oor_top", 1'b0, 1'b1);
        idle(); idle();

        fetch(0);
        step(1'b1, 64'd4, 1'b1, 1'b0, 1'b0, '0, 8'h00);
        expect_out(1, "stall_l2", 1'b0, 32'h0);
        idle();    expect_out(1, "after_stall_l2", 1'b1, 32'h0060_0593);
        fetch(4); idle();
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 8'h00);
        expect_out(1, "hold_l2", 1'b1, 32'h0060_0E93);
        idle(); idle();

        fetch(0); fetch(4);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 8'h00);
        expect_out(1, "flush_a_l2", 1'b0, 32'h0);
        expect_out(0, "flush_a_l1", 1'b0, 32'h0);
        idle();    expect_out(1, "flush_b_l2", 1'b0, 32'h0);
        fetch(0); fetch(4);
        step(1'b1, 64'd8, 1'b0, 1'b1, 1'b0, '0, 8'h00);
        expect_out(1, "flushacc_l2", 1'b0, 32'h0);
        expect_out(0, "flushacc_l1", 1'b1, 32'h0000_0F13);
        idle();    expect_out(1, "flushacc_next_l2", 1'b1, 32'h0000_0F13);

        step(1'b1, 64'd16, 1'b0, 1'b0, 1'b1, 64'd16, 8'h37);
        step(1'b1, 64'd16, 1'b0, 1'b0, 1'b1, 64'd17, 8'h05);
        step(1'b1, 64'd16, 1'b0, 1'b0, 1'b1, 64'd18, 8'h00);
        step(1'b1, 64'd16, 1'b0, 1'b0, 1'b1, 64'd19, 8'h80);
        fetch(16); expect_out(0, "raw_l1", 1'b1, 32'h8000_0537);

        fetch(16);
        fetch_req = 1'b0;
        reset = 1'b0;
        #1;
        expect_out(0, "midrst_l1", 1'b0, 32'h0);
        expect_out(1, "midrst_l2", 1'b0, 32'h0);
        clear_model();
        @(negedge clk);
        #1;
        reset = 1'b1;
        fetch(16); expect_out(0, "refetch_l1", 1'b1, 32'h8000_0537);
        idle();    expect_out(1, "refetch_l2", 1'b1, 32'h8000_0537);

        for (int i = 0; i < int'(N_RAND); i++) begin
            logic [AW-1:0] a, pa;
            bit            rq, st, fl, we;
            case ($urandom_range(9))
                0:       a = {$urandom, $urandom};
                1, 2:    a = AW'($urandom_range(DEPTH + 7));
                default: a = AW'($urandom_range(DEPTH / 4 + 1)) * 4;
            endcase
            pa = ($urandom_range(15) == 0) ? {$urandom, $urandom} : AW'($urandom_range(DEPTH + 3));
            rq = ($urandom_range(9) < 7);
            st = ($urandom_range(19) < 3);
            fl = ($urandom_range(19) < 2);
            we = ($urandom_range(9) == 0);
            step(rq, a, st, fl, we, pa, 8'($urandom));
        end
        repeat (4) idle();

        check("sb_empty_l1", 128'(sb0.size()), 128'(0));
        check("sb_empty_l2", 128'(sb1.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
